// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; owns the PC, buffers {pc,inst} pairs for decode.
// Latency: first instruction valid 1 cycle after reset release, 2 cycles after a redirect.
// Backpressure: out_ready low fills the FIFO, then the PC holds. Macro FETCH_PERF_EN adds perf counters.
module fetch_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter logic [PC_W-1:0] LAST_PC  = 8'h4C,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     perf_fetch_cnt,
  output logic [15:0]     perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   cnt_after_pop;
  logic [PC_W-1:0] head_pc_q, head_pc_d;
  logic [31:0]     head_inst_q, head_inst_d;

  logic [PC_W-1:0] fpc_q   [DEPTH];
  logic [31:0]     finst_q [DEPTH];

  logic full;
  logic hs;       // decode handshake on the head this cycle
  logic pop;      // head advance (a redirect flushes instead)
  logic push;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign out_inst  = head_inst_q;
  assign out_pc    = head_pc_q;
  assign halted    = (state_q == ST_HALT);

  assign full = (count_q == FULL_CNT);
  assign hs   = out_valid && out_ready;
  assign pop  = hs && !redirect_valid;
  assign push = (state_q == ST_RUN) && !redirect_valid && (!full || hs);

  // Next-state for PC, FSM, FIFO pointers/occupancy and the registered head.
  always_comb begin
    pc_d          = pc_q;
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    head_pc_d     = head_pc_q;
    head_inst_d   = head_inst_q;
    cnt_after_pop = count_q - (pop ? CW'(1) : CW'(0));

    if (redirect_valid) begin
      pc_d     = {redirect_pc[PC_W-1:2], 2'b00};
      state_d  = ST_RUN;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        pc_d     = pc_q + PC_W'(4);
        if (pc_q == LAST_PC) begin
          state_d = ST_HALT;
        end
      end
      count_d = cnt_after_pop + (push ? CW'(1) : CW'(0));

      // Head follows the new read pointer; a push into an otherwise empty
      // FIFO bypasses storage so the word is visible the next cycle.
      if (count_d != '0) begin
        if (push && (cnt_after_pop == '0)) begin
          head_pc_d   = pc_q;
          head_inst_d = imem_data;
        end else begin
          head_pc_d   = fpc_q[rd_ptr_d];
          head_inst_d = finst_q[rd_ptr_d];
        end
      end
    end
  end

  // Control and head registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_pc_q   <= '0;
      head_inst_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
    end
  end

  // FIFO storage; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fpc_q[wr_ptr_q]   <= pc_q;
      finst_q[wr_ptr_q] <= imem_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_stall_q;
  logic        stall;

  assign stall          = (state_q == ST_RUN) && !redirect_valid && full && !hs;
  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;

  // Saturating push and full-FIFO stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && (perf_fetch_q != 16'hFFFF)) begin
        perf_fetch_q <= perf_fetch_q + 16'd1;
      end
      if (stall && (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the combinational instruction memory.
- Owns the program counter and drives the memory byte address; the memory indexes words by addr[7:2].
- Buffers fetched {pc, instruction} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush) and halts at the last programmed word.

Parameters:
- PC_W, 8, PC / memory byte-address width.
- RESET_PC, 8'h00, PC value loaded on reset.
- LAST_PC, 8'h4C, byte address of the last valid instruction word (word 19).
- DEPTH, 2, fetch FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  PC_W  byte address to instruction memory (equals the current PC).
- imem_data  in  32  instruction word; combinational from imem_addr, same cycle.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction.
- out_pc  out  PC_W  byte address of the head instruction.
- redirect_valid  in  1  branch/jump taken; flush and restart.
- redirect_pc  in  PC_W  restart target; bits [1:0] are forced to 0.
- halted  out  1  fetch has passed LAST_PC and stopped.

Behaviour:
- Reset, synchronous on a clk edge with rst=1:
  - pc=RESET_PC.
  - FIFO empty; out_valid=0, out_inst=0, out_pc=0.
  - halted=0; state=RUN.
- imem_addr is driven from the pc register at all times.
- States:
  - RUN: fetching.
  - HALT: fetching stopped.
- Transitions:
  - RUN→HALT when a push occurs with pc==LAST_PC.
  - HALT→RUN only on redirect_valid.
  - rst forces RUN from either state.
- Push condition, all must hold:
  - state==RUN,
  - redirect_valid==0,
  - FIFO not full, or a pop occurs this cycle.
- On push:
  - {pc, imem_data} written to the FIFO tail.
  - pc<=pc+4, modulo 2^PC_W (wraps 8'hFC→8'h00).
  - Entering HALT still pushes the LAST_PC word.
- Pop: occurs when out_valid && out_ready; head advances. Outputs are driven from FIFO storage (registered), not from imem_data.
- Latency:
  - First instruction appears on out_valid one cycle after rst deasserts.
  - Steady-state throughput is 1 instruction/cycle with out_ready held high.
- Full FIFO without a pop: pc holds and no push; imem_addr is stable.
- Full FIFO with a pop in the same cycle: push and pop both happen; occupancy is unchanged.
- Empty FIFO: out_valid=0. out_inst and out_pc hold their last values; the consumer ignores them.
- Redirect (highest priority, overrides push and pop):
  - FIFO flushed; out_valid=0 next cycle.
  - pc<=redirect_pc&~3; state<=RUN; halted<=0.
  - A head transfer with out_valid&&out_ready in the same cycle counts as consumed by decode.
  - The first post-redirect instruction is valid 2 cycles after the redirect edge: 1 cycle to load pc, 1 cycle to push.
- halted equals (state==HALT), registered. In HALT the FIFO continues to drain normally.
- Occupancy counter width is clog2(DEPTH)+1; no overflow or underflow is reachable.
- rst mid-operation discards all FIFO contents and any pending redirect.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, two extra output ports are added, both cleared by rst and saturating at 16'hFFFF:
  - perf_fetch_cnt, 16 bits, out: +1 per push.
  - perf_stall_cnt, 16 bits, out: +1 per cycle in RUN where push is blocked by a full FIFO without a pop.
- Redirect cycles are not counted in either counter.
- When not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, out_ready=1, 22-word program image → out_pc sequence is 00,04,…,4C on consecutive cycles with out_inst matching memory words 0..19. halted=1 after the 4C push; out_valid=0 from the cycle after 4C is popped.
- out_ready=0 from reset → FIFO fills after DEPTH=2 pushes and imem_addr holds 8'h08. Raising out_ready delivers 00,04,08 in order with no loss or duplication.
- Redirect to 8'h22 at pc=8'h10 with the FIFO holding 08,0C → next valid out_pc is 8'h20 (2 cycles later); 08 and 0C are never presented.
- From HALT, redirect_valid with redirect_pc=8'h00 → halted falls next cycle and fetching restarts at 00.
- rst asserted while the FIFO is full and state is HALT → next cycle out_valid=0, halted=0, imem_addr=RESET_PC.
- FETCH_PERF_EN defined, out_ready=0 for 10 cycles after reset → perf_fetch_cnt=2, perf_stall_cnt=8.
